// File: rtl/bram_latency_ctrl.sv
// bram_latency_ctrl
// Pipelined single-port BRAM controller that sits directly behind the CPU/DMA arbiter.
// It accepts one read or write per cycle and never stalls. Read data comes back exactly
// DELAYS cycles after issue and is steered to the CPU or the DMA side by a per-request tag.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock; asynchronous active-high reset
//   in_valid, wr             request strobe; 1 = write, 0 = read
//   addr, data_in            word address; write data
//   reader_sel               read destination: 1 = CPU, 0 = DMA
//   CPU_get_data, cpu_data_o one-cycle CPU return pulse and its data
//   dma_data_valid, dma_data_o one-cycle DMA return pulse and its data
//   rd_pending               number of reads issued but not yet returned
//   stat_rd_cnt, stat_wr_cnt saturating request counters (BRAM_LATENCY_CTRL_STATS_EN only)
//
// Optional feature macro: BRAM_LATENCY_CTRL_STATS_EN
module bram_latency_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DELAYS     = 10   // legal range 1..64
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  in_valid,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  reader_sel,
  output logic                  CPU_get_data,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  dma_data_valid,
  output logic [DATA_WIDTH-1:0] dma_data_o,
  output logic [6:0]            rd_pending
`ifdef BRAM_LATENCY_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt
`endif
);

  logic w_rd;
  logic w_wr;
  logic w_ret;
  logic w_ret_sel;
  logic [DATA_WIDTH-1:0] w_ret_data;

  assign w_rd = in_valid & ~wr;
  assign w_wr = in_valid & wr;

  logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

  // Pipeline stage DELAYS-1 feeds the output registers. The result therefore becomes
  // visible DELAYS edges after the issuing edge.
  logic [DELAYS-1:0]     r_pipe_vld;
  logic [DELAYS-1:0]     r_pipe_sel;
  logic [DATA_WIDTH-1:0] r_pipe_data [DELAYS];

  logic                  r_cpu_get_data;
  logic [DATA_WIDTH-1:0] r_cpu_data;
  logic                  r_dma_data_valid;
  logic [DATA_WIDTH-1:0] r_dma_data;
  logic [6:0]            r_rd_pending;

  assign w_ret      = r_pipe_vld[DELAYS-1];
  assign w_ret_sel  = r_pipe_sel[DELAYS-1];
  assign w_ret_data = r_pipe_data[DELAYS-1];

  // Memory and data pipeline carry no reset, which keeps them mappable onto block RAM
  // and plain shift registers. Only the valid bits decide what reaches the outputs.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      r_mem[addr] <= data_in;
    end
    r_pipe_data[0] <= r_mem[addr];
    for (int unsigned i = 1; i < DELAYS; i++) begin
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pipe_vld       <= '0;
      r_pipe_sel       <= '0;
      r_cpu_get_data   <= 1'b0;
      r_cpu_data       <= '0;
      r_dma_data_valid <= 1'b0;
      r_dma_data       <= '0;
      r_rd_pending     <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd;
      r_pipe_sel[0] <= reader_sel;
      for (int unsigned i = 1; i < DELAYS; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_sel[i] <= r_pipe_sel[i-1];
      end

      r_cpu_get_data   <= w_ret & w_ret_sel;
      r_dma_data_valid <= w_ret & ~w_ret_sel;
      // The idle side keeps its last data value.
      if (w_ret && w_ret_sel) begin
        r_cpu_data <= w_ret_data;
      end
      if (w_ret && !w_ret_sel) begin
        r_dma_data <= w_ret_data;
      end

      unique case ({w_rd, w_ret})
        2'b10:   r_rd_pending <= r_rd_pending + 7'd1;
        2'b01:   r_rd_pending <= r_rd_pending - 7'd1;
        default: r_rd_pending <= r_rd_pending;
      endcase
    end
  end

  assign CPU_get_data   = r_cpu_get_data;
  assign cpu_data_o     = r_cpu_data;
  assign dma_data_valid = r_dma_data_valid;
  assign dma_data_o     = r_dma_data;
  assign rd_pending     = r_rd_pending;

`ifdef BRAM_LATENCY_CTRL_STATS_EN
  logic [31:0] r_stat_rd_cnt;
  logic [31:0] r_stat_wr_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (w_rd && (r_stat_rd_cnt != 32'hFFFF_FFFF)) begin
        r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
      end
      if (w_wr && (r_stat_wr_cnt != 32'hFFFF_FFFF)) begin
        r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule

// File: tb/tb_bram_latency_ctrl.sv
// Self-checking bench for bram_latency_ctrl. A reference model holds a plain memory array
// and a queue of outstanding reads tagged with their due edge. After every clock edge all
// outputs are compared against that model.
module tb_bram_latency_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;
  parameter int DELAYS = 10;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          in_valid;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          reader_sel;
  logic          CPU_get_data;
  logic [DW-1:0] cpu_data_o;
  logic          dma_data_valid;
  logic [DW-1:0] dma_data_o;
  logic [6:0]    rd_pending;
`ifdef BRAM_LATENCY_CTRL_STATS_EN
  logic [31:0]   stat_rd_cnt;
  logic [31:0]   stat_wr_cnt;
`endif

  bram_latency_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DELAYS    (DELAYS)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .in_valid      (in_valid),
    .wr            (wr),
    .addr          (addr),
    .data_in       (data_in),
    .reader_sel    (reader_sel),
    .CPU_get_data  (CPU_get_data),
    .cpu_data_o    (cpu_data_o),
    .dma_data_valid(dma_data_valid),
    .dma_data_o    (dma_data_o),
    .rd_pending    (rd_pending)
`ifdef BRAM_LATENCY_CTRL_STATS_EN
    ,
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_wr_cnt   (stat_wr_cnt)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int          due;
    logic        sel;
    logic [DW-1:0] data;
  } ret_t;

  int            total = 0;
  int            bad   = 0;
  int            edge_n = 0;
  int            peak_pend;
  logic [DW-1:0] mmem [int];
  ret_t          q[$];
  logic [DW-1:0] e_cpu_d;
  logic [DW-1:0] e_dma_d;
  longint        e_rd;
  longint        e_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_cpu_v;
    logic e_dma_v;
    ret_t r;
    e_cpu_v = 1'b0;
    e_dma_v = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      r = q.pop_front();
      if (r.sel) begin
        e_cpu_v = 1'b1;
        e_cpu_d = r.data;
      end else begin
        e_dma_v = 1'b1;
        e_dma_d = r.data;
      end
    end
    chk("CPU_get_data", 64'(CPU_get_data), 64'(e_cpu_v));
    chk("dma_data_valid", 64'(dma_data_valid), 64'(e_dma_v));
    chk("cpu_data_o", 64'(cpu_data_o), 64'(e_cpu_d));
    chk("dma_data_o", 64'(dma_data_o), 64'(e_dma_d));
    chk("rd_pending", 64'(rd_pending), 64'(q.size()));
`ifdef BRAM_LATENCY_CTRL_STATS_EN
    chk("stat_rd_cnt", 64'(stat_rd_cnt), 64'(e_rd));
    chk("stat_wr_cnt", 64'(stat_wr_cnt), 64'(e_wr));
`endif
    if (int'(rd_pending) > peak_pend) peak_pend = int'(rd_pending);
  endtask

  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic s);
    @(negedge wb_clk_i);
    in_valid   = v;
    wr         = w;
    addr       = a;
    data_in    = d;
    reader_sel = s;
    @(posedge wb_clk_i);
    edge_n++;
    if (v && w) begin
      mmem[int'(a)] = d;
      e_wr++;
    end else if (v) begin
      q.push_back('{due: edge_n + DELAYS, sel: s, data: mmem[int'(a)]});
      e_rd++;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic read(input logic [AW-1:0] a, input logic s);
    step(1'b1, 1'b0, a, $urandom, s);
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    in_valid = 1'b0;
    #1;
    q.delete();
    e_cpu_d = '0;
    e_dma_d = '0;
    e_rd    = 0;
    e_wr    = 0;
    check_outputs();
    @(posedge wb_clk_i);
    edge_n++;
    @(posedge wb_clk_i);
    edge_n++;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    wb_rst_i   = 1'b1;
    in_valid   = 1'b0;
    wr         = 1'b0;
    addr       = '0;
    data_in    = '0;
    reader_sel = 1'b0;
    e_cpu_d    = '0;
    e_dma_d    = '0;
    e_rd       = 0;
    e_wr       = 0;
    peak_pend  = 0;
    #1;
    check_outputs();
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    check_outputs();

    // Write then read back on the CPU side.
    write(13'h0010, 32'hDEAD_BEEF);
    read(13'h0010, 1'b1);
    idle(DELAYS + 1);

    // Burst of eight back-to-back CPU reads.
    for (int i = 0; i < 8; i++) write(AW'(i), DW'(100 + i));
    peak_pend = 0;
    for (int i = 0; i < 8; i++) read(AW'(i), 1'b1);
    idle(DELAYS + 1);
    chk("burst_peak_pending", 64'(peak_pend), 64'((DELAYS < 8) ? DELAYS : 8));

    // Alternating DMA/CPU routing.
    write(AW'(20), 32'd7);
    write(AW'(21), 32'd9);
    read(AW'(20), 1'b0);
    read(AW'(21), 1'b1);
    read(AW'(20), 1'b0);
    read(AW'(21), 1'b1);
    idle(DELAYS + 1);

    // Bubbles and write interleave.
    write(AW'(5), 32'd44);
    read(AW'(5), 1'b1);
    idle(1);
    write(AW'(5), 32'd55);
    idle(1);
    read(AW'(5), 1'b0);
    idle(DELAYS + 1);

    // Reset with reads in flight: no returns afterwards, memory retained.
    write(AW'(30), 32'h0000_1234);
    read(AW'(30), 1'b1);
    read(AW'(5), 1'b0);
    read(AW'(21), 1'b1);
    idle(4);
    do_reset();
    idle(DELAYS + 2);
    read(AW'(30), 1'b1);
    idle(DELAYS + 1);

    // Random traffic over a preloaded window.
    for (int i = 0; i < 32; i++) write(AW'(i), $urandom);
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 31)),
           $urandom, 1'($urandom));
    end
    // Sustained read/write alternation.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) read(AW'($urandom_range(0, 31)), 1'($urandom));
      else write(AW'($urandom_range(0, 31)), $urandom);
    end
    idle(DELAYS + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
